// File: rtl/ct_vfpu_fwd_vreg_gen_if.sv
// Issue and forward bus of one VFPU pipe's vreg forward generator.
// master = forward producer, slave = issue side / forward consumer.
interface ct_vfpu_fwd_vreg_gen_if #(
    parameter int VREG_W = 7,
    parameter int DATA_W = 64
);
    logic              ex1_inst_vld;
    logic              ex1_dst_vld;
    logic [VREG_W-1:0] ex1_dst_vreg;
    logic [1:0]        ex1_lat;
    logic              pipe_stall;
    logic              rtu_yy_xx_flush;
    logic [DATA_W-1:0] ex3_result;
    logic [DATA_W-1:0] ex4_result;
    logic [DATA_W-1:0] ex5_result;

    logic [VREG_W-1:0] ex3_fwd_vreg;
    logic              ex3_fwd_vreg_vld;
    logic [DATA_W-1:0] ex3_fwd_vreg_data;
    logic [VREG_W-1:0] ex4_fwd_vreg;
    logic              ex4_fwd_vreg_vld;
    logic [DATA_W-1:0] ex4_fwd_vreg_data;
    logic [VREG_W-1:0] ex5_fwd_vreg;
    logic              ex5_fwd_vreg_vld;
    logic [DATA_W-1:0] ex5_wb_vreg_data;

    modport master (
        input  ex1_inst_vld, ex1_dst_vld, ex1_dst_vreg, ex1_lat,
        input  pipe_stall, rtu_yy_xx_flush,
        input  ex3_result, ex4_result, ex5_result,
        output ex3_fwd_vreg, ex3_fwd_vreg_vld, ex3_fwd_vreg_data,
        output ex4_fwd_vreg, ex4_fwd_vreg_vld, ex4_fwd_vreg_data,
        output ex5_fwd_vreg, ex5_fwd_vreg_vld, ex5_wb_vreg_data
    );

    modport slave (
        output ex1_inst_vld, ex1_dst_vld, ex1_dst_vreg, ex1_lat,
        output pipe_stall, rtu_yy_xx_flush,
        output ex3_result, ex4_result, ex5_result,
        input  ex3_fwd_vreg, ex3_fwd_vreg_vld, ex3_fwd_vreg_data,
        input  ex4_fwd_vreg, ex4_fwd_vreg_vld, ex4_fwd_vreg_data,
        input  ex5_fwd_vreg, ex5_fwd_vreg_vld, ex5_wb_vreg_data
    );
endinterface

// File: rtl/ct_vfpu_fwd_vreg_gen.sv
// VFPU pipe vreg forward generator: tracks dst tags ex2..ex5 and drives
// ex3/ex4/ex5 forward tags, valids and data. Option: VFPU_FWD_EX3_EN.
module ct_vfpu_fwd_vreg_gen #(
    parameter int VREG_W = 7,
    parameter int DATA_W = 64
) (
    input logic                        forever_cpuclk,
    input logic                        cpurst_b,
    ct_vfpu_fwd_vreg_gen_if.master     bus
);

    localparam logic [1:0] LAT_EX3 = 2'b01;
    localparam logic [1:0] LAT_EX4 = 2'b10;
    localparam logic [1:0] LAT_EX5 = 2'b11;

    logic              adv;
    logic              flush;
    logic              ex1_load;

    logic              ex2_vld, ex3_vld, ex4_vld, ex5_vld;
    logic [VREG_W-1:0] ex2_vreg, ex3_vreg, ex4_vreg, ex5_vreg;
    logic [1:0]        ex2_lat, ex3_lat, ex4_lat, ex5_lat;

    logic [DATA_W-1:0] ex4_data_q;
    logic [DATA_W-1:0] ex5_data_q;

    logic              ex3_fwd_vld;
    logic              ex4_fwd_vld;
    logic              ex4_cap_ex3;
    logic              ex5_cap_ex4;
    logic [DATA_W-1:0] ex3_fwd_data;
    logic [DATA_W-1:0] ex4_fwd_data;
    logic [DATA_W-1:0] ex5_fwd_data;

    assign adv      = ~bus.pipe_stall;
    assign flush    = bus.rtu_yy_xx_flush;
    assign ex1_load = bus.ex1_inst_vld & bus.ex1_dst_vld
                    & (bus.ex1_lat != 2'b00);

    // Stage valids: flush kills ex2..ex4 even under stall; ex5 is committed.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ex2_vld <= 1'b0;
            ex3_vld <= 1'b0;
            ex4_vld <= 1'b0;
            ex5_vld <= 1'b0;
        end else begin
            if (flush) begin
                ex2_vld <= 1'b0;
                ex3_vld <= 1'b0;
                ex4_vld <= 1'b0;
            end else if (adv) begin
                ex2_vld <= ex1_load;
                ex3_vld <= ex2_vld;
                ex4_vld <= ex3_vld;
            end
            if (adv) begin
                ex5_vld <= ex4_vld;
            end
        end
    end

    // Tags and latency fields shift on every advance; they hold under stall.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ex2_vreg <= '0;
            ex3_vreg <= '0;
            ex4_vreg <= '0;
            ex5_vreg <= '0;
            ex2_lat  <= 2'b00;
            ex3_lat  <= 2'b00;
            ex4_lat  <= 2'b00;
            ex5_lat  <= 2'b00;
        end else if (adv) begin
            ex2_vreg <= bus.ex1_dst_vreg;
            ex3_vreg <= ex2_vreg;
            ex4_vreg <= ex3_vreg;
            ex5_vreg <= ex4_vreg;
            ex2_lat  <= bus.ex1_lat;
            ex3_lat  <= ex2_lat;
            ex4_lat  <= ex3_lat;
            ex5_lat  <= ex4_lat;
        end
    end

    assign ex4_cap_ex3 = adv & ex3_vld & (ex3_lat == LAT_EX3);
    assign ex5_cap_ex4 = adv & ex4_fwd_vld;

    // Early results are carried along so later stages can still forward them.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ex4_data_q <= '0;
            ex5_data_q <= '0;
        end else begin
            if (ex4_cap_ex3) begin
                ex4_data_q <= bus.ex3_result;
            end
            if (ex5_cap_ex4) begin
                ex5_data_q <= ex4_fwd_data;
            end
        end
    end

    // Forward valids and data, zeroed when not valid.
    always_comb begin
        ex3_fwd_vld  = 1'b0;
        ex3_fwd_data = '0;
`ifdef VFPU_FWD_EX3_EN
        ex3_fwd_vld  = ex3_vld & (ex3_lat == LAT_EX3);
        if (ex3_fwd_vld) begin
            ex3_fwd_data = bus.ex3_result;
        end
`endif
        ex4_fwd_vld  = ex4_vld
                     & ((ex4_lat == LAT_EX3) | (ex4_lat == LAT_EX4));
        ex4_fwd_data = '0;
        if (ex4_fwd_vld) begin
            ex4_fwd_data = (ex4_lat == LAT_EX4) ? bus.ex4_result
                                                 : ex4_data_q;
        end
        ex5_fwd_data = '0;
        if (ex5_vld) begin
            ex5_fwd_data = (ex5_lat == LAT_EX5) ? bus.ex5_result
                                                 : ex5_data_q;
        end
    end

    assign bus.ex3_fwd_vreg      = ex3_vreg;
    assign bus.ex3_fwd_vreg_vld  = ex3_fwd_vld;
    assign bus.ex3_fwd_vreg_data = ex3_fwd_data;
    assign bus.ex4_fwd_vreg      = ex4_vreg;
    assign bus.ex4_fwd_vreg_vld  = ex4_fwd_vld;
    assign bus.ex4_fwd_vreg_data = ex4_fwd_data;
    assign bus.ex5_fwd_vreg      = ex5_vreg;
    assign bus.ex5_fwd_vreg_vld  = ex5_vld;
    assign bus.ex5_wb_vreg_data  = ex5_fwd_data;

endmodule

// File: tb/tb_ct_vfpu_fwd_vreg_gen.sv
// Bench for ct_vfpu_fwd_vreg_gen: queue-of-instructions model plus
// directed literal checks. Works with or without VFPU_FWD_EX3_EN.
module tb_ct_vfpu_fwd_vreg_gen;

`ifdef VFPU_FWD_EX3_EN
    localparam bit EX3EN = 1'b1;
`else
    localparam bit EX3EN = 1'b0;
`endif

    logic clk;
    logic rst_b;
    int   checks;
    int   errors;

    ct_vfpu_fwd_vreg_gen_if #(.VREG_W(7), .DATA_W(64)) bus ();

    ct_vfpu_fwd_vreg_gen #(.VREG_W(7), .DATA_W(64)) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_b),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          stage;
        logic [6:0]  vreg;
        logic [1:0]  lat;
        logic [63:0] dat;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic int find(input int s);
        foreach (q[i]) if (q[i].stage == s) return i;
        return -1;
    endfunction

    task automatic drive(input logic iv, input logic dv,
                         input logic [6:0] vr, input logic [1:0] lat,
                         input logic st, input logic fl,
                         input logic [63:0] r3, input logic [63:0] r4,
                         input logic [63:0] r5);
        bus.ex1_inst_vld    = iv;
        bus.ex1_dst_vld     = dv;
        bus.ex1_dst_vreg    = vr;
        bus.ex1_lat         = lat;
        bus.pipe_stall      = st;
        bus.rtu_yy_xx_flush = fl;
        bus.ex3_result      = r3;
        bus.ex4_result      = r4;
        bus.ex5_result      = r5;
    endtask

    task automatic idle_drive();
        drive(0, 0, 7'(($urandom)), 2'(($urandom)), 0, 0,
              rnd64(), rnd64(), rnd64());
    endtask

    // Model view of what an instruction in ex4 forwards this cycle.
    function automatic logic [63:0] m_ex4_val(input ent_t e);
        return (e.lat == 2'b10) ? bus.ex4_result : e.dat;
    endfunction

    // Compare all outputs against the instruction queue model.
    task automatic compare_now();
        int i3, i4, i5;
        logic v3, v4;
        @(negedge clk);
        i3 = find(3);
        i4 = find(4);
        i5 = find(5);
        v3 = EX3EN && (i3 >= 0) && (q[i3].lat == 2'b01);
        chk("m_ex3_vld", 64'(bus.ex3_fwd_vreg_vld), 64'(v3));
        chk("m_ex3_data", bus.ex3_fwd_vreg_data,
            v3 ? bus.ex3_result : 64'h0);
        if (i3 >= 0)
            chk("m_ex3_tag", 64'(bus.ex3_fwd_vreg), 64'(q[i3].vreg));
        v4 = (i4 >= 0) && (q[i4].lat inside {2'b01, 2'b10});
        chk("m_ex4_vld", 64'(bus.ex4_fwd_vreg_vld), 64'(v4));
        chk("m_ex4_data", bus.ex4_fwd_vreg_data,
            v4 ? m_ex4_val(q[i4]) : 64'h0);
        if (i4 >= 0)
            chk("m_ex4_tag", 64'(bus.ex4_fwd_vreg), 64'(q[i4].vreg));
        chk("m_ex5_vld", 64'(bus.ex5_fwd_vreg_vld), 64'(i5 >= 0));
        if (i5 >= 0) begin
            chk("m_ex5_tag", 64'(bus.ex5_fwd_vreg), 64'(q[i5].vreg));
            chk("m_ex5_data", bus.ex5_wb_vreg_data,
                (q[i5].lat == 2'b11) ? bus.ex5_result : q[i5].dat);
        end else begin
            chk("m_ex5_data", bus.ex5_wb_vreg_data, 64'h0);
        end
    endtask

    // Move the model one clock using the inputs held across the edge.
    task automatic model_step();
        ent_t nq[$];
        ent_t e;
        logic st, fl;
        st = bus.pipe_stall;
        fl = bus.rtu_yy_xx_flush;
        if (st && !fl) return;
        foreach (q[i]) begin
            e = q[i];
            if (fl) begin
                if (e.stage == 4 && !st) begin
                    e.dat   = m_ex4_val(e);
                    e.stage = 5;
                    nq.push_back(e);
                end else if (e.stage == 5 && st) begin
                    nq.push_back(e);
                end
            end else if (e.stage != 5) begin
                if (e.stage == 3 && e.lat == 2'b01) e.dat = bus.ex3_result;
                if (e.stage == 4) e.dat = m_ex4_val(e);
                e.stage = e.stage + 1;
                nq.push_back(e);
            end
        end
        if (!fl && !st && bus.ex1_inst_vld && bus.ex1_dst_vld
            && bus.ex1_lat != 2'b00) begin
            e.stage = 2;
            e.vreg  = bus.ex1_dst_vreg;
            e.lat   = bus.ex1_lat;
            e.dat   = 64'h0;
            nq.push_back(e);
        end
        q = nq;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            idle_drive();
            compare_now();
            advance();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vld"}, 64'({bus.ex3_fwd_vreg_vld, bus.ex4_fwd_vreg_vld,
                               bus.ex5_fwd_vreg_vld}), 64'h0);
        chk({tag, "_tag"}, 64'({bus.ex3_fwd_vreg, bus.ex4_fwd_vreg,
                               bus.ex5_fwd_vreg}), 64'h0);
        chk({tag, "_d3"}, bus.ex3_fwd_vreg_data, 64'h0);
        chk({tag, "_d4"}, bus.ex4_fwd_vreg_data, 64'h0);
        chk({tag, "_d5"}, bus.ex5_wb_vreg_data, 64'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_b  = 1'b0;
        drive(0, 0, 7'h0, 2'b00, 0, 0, 64'h11, 64'h22, 64'h33);
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;

        // lat=ex3, vreg 12, ex3 result A5A5
        drive(1, 1, 7'h12, 2'b01, 0, 0, rnd64(), rnd64(), rnd64());
        compare_now(); advance();
        idle(1);
        drive(0, 0, 7'h0, 2'b00, 0, 0, 64'hA5A5, rnd64(), rnd64());
        compare_now();
        chk("t1_ex3_vld", 64'(bus.ex3_fwd_vreg_vld), 64'(EX3EN));
        chk("t1_ex3_tag", 64'(bus.ex3_fwd_vreg), 64'h12);
        chk("t1_ex3_data", bus.ex3_fwd_vreg_data,
            EX3EN ? 64'hA5A5 : 64'h0);
        advance();
        idle_drive(); compare_now();
        chk("t1_ex4_vld", 64'(bus.ex4_fwd_vreg_vld), 64'h1);
        chk("t1_ex4_tag", 64'(bus.ex4_fwd_vreg), 64'h12);
        chk("t1_ex4_data", bus.ex4_fwd_vreg_data, 64'hA5A5);
        advance();
        idle_drive(); compare_now();
        chk("t1_ex5_vld", 64'(bus.ex5_fwd_vreg_vld), 64'h1);
        chk("t1_ex5_data", bus.ex5_wb_vreg_data, 64'hA5A5);
        advance();
        idle_drive(); compare_now();
        chk("t1_drained", 64'({bus.ex3_fwd_vreg_vld, bus.ex4_fwd_vreg_vld,
                              bus.ex5_fwd_vreg_vld}), 64'h0);
        advance();

        // lat=ex5, vreg 3F
        drive(1, 1, 7'h3F, 2'b11, 0, 0, rnd64(), rnd64(), rnd64());
        compare_now(); advance();
        idle(1);
        idle_drive(); compare_now();
        chk("t2_ex3_vld", 64'(bus.ex3_fwd_vreg_vld), 64'h0);
        advance();
        idle_drive(); compare_now();
        chk("t2_ex4_vld", 64'(bus.ex4_fwd_vreg_vld), 64'h0);
        chk("t2_ex4_data", bus.ex4_fwd_vreg_data, 64'h0);
        advance();
        drive(0, 0, 7'h0, 2'b00, 0, 0, rnd64(), rnd64(), 64'h1234);
        compare_now();
        chk("t2_ex5_vld", 64'(bus.ex5_fwd_vreg_vld), 64'h1);
        chk("t2_ex5_tag", 64'(bus.ex5_fwd_vreg), 64'h3F);
        chk("t2_ex5_data", bus.ex5_wb_vreg_data, 64'h1234);
        advance();
        idle(2);

        // back-to-back: v1 lat4, v2 lat3, v3 lat5
        drive(1, 1, 7'h01, 2'b10, 0, 0, rnd64(), rnd64(), rnd64());
        compare_now(); advance();
        drive(1, 1, 7'h02, 2'b01, 0, 0, rnd64(), rnd64(), rnd64());
        compare_now(); advance();
        drive(1, 1, 7'h03, 2'b11, 0, 0, rnd64(), rnd64(), rnd64());
        compare_now(); advance();
        drive(0, 0, 7'h0, 2'b00, 0, 0, 64'h2222, 64'h1111, rnd64());
        compare_now();
        chk("t3_ex4_tag", 64'(bus.ex4_fwd_vreg), 64'h01);
        chk("t3_ex4_data", bus.ex4_fwd_vreg_data, 64'h1111);
        chk("t3_ex3_tag", 64'(bus.ex3_fwd_vreg), 64'h02);
        advance();
        drive(0, 0, 7'h0, 2'b00, 0, 0, rnd64(), rnd64(), rnd64());
        compare_now();
        chk("t3_ex5_data", bus.ex5_wb_vreg_data, 64'h1111);
        chk("t3_ex4_data2", bus.ex4_fwd_vreg_data, 64'h2222);
        advance();
        idle(4);

        // stall 3 cycles with lat=ex3 entry in ex4
        drive(1, 1, 7'h05, 2'b01, 0, 0, rnd64(), rnd64(), rnd64());
        compare_now(); advance();
        idle(1);
        drive(0, 0, 7'h0, 2'b00, 0, 0, 64'h77, rnd64(), rnd64());
        compare_now(); advance();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 7'h0, 2'b00, k < 3, 0, rnd64(), rnd64(), rnd64());
            compare_now();
            chk("t4_stall_vld", 64'(bus.ex4_fwd_vreg_vld), 64'h1);
            chk("t4_stall_tag", 64'(bus.ex4_fwd_vreg), 64'h05);
            chk("t4_stall_data", bus.ex4_fwd_vreg_data, 64'h77);
            advance();
        end
        idle_drive(); compare_now();
        chk("t4_ex5_data", bus.ex5_wb_vreg_data, 64'h77);
        advance();
        idle(2);

        // flush with ex2..ex5 occupied
        drive(1, 1, 7'h20, 2'b01, 0, 0, rnd64(), rnd64(), rnd64());
        compare_now(); advance();
        drive(1, 1, 7'h21, 2'b10, 0, 0, rnd64(), rnd64(), rnd64());
        compare_now(); advance();
        drive(1, 1, 7'h22, 2'b01, 0, 0, rnd64(), rnd64(), rnd64());
        compare_now(); advance();
        drive(1, 1, 7'h23, 2'b11, 0, 0, rnd64(), rnd64(), rnd64());
        compare_now(); advance();
        drive(1, 1, 7'h24, 2'b01, 0, 1, rnd64(), 64'hBEEF, rnd64());
        compare_now();
        chk("t5_pre_ex5", 64'(bus.ex5_fwd_vreg), 64'h20);
        advance();
        idle_drive(); compare_now();
        chk("t5_ex3_vld", 64'(bus.ex3_fwd_vreg_vld), 64'h0);
        chk("t5_ex4_vld", 64'(bus.ex4_fwd_vreg_vld), 64'h0);
        chk("t5_ex5_vld", 64'(bus.ex5_fwd_vreg_vld), 64'h1);
        chk("t5_ex5_tag", 64'(bus.ex5_fwd_vreg), 64'h21);
        chk("t5_ex5_data", bus.ex5_wb_vreg_data, 64'hBEEF);
        advance();
        idle_drive(); compare_now();
        chk("t5_empty", 64'({bus.ex3_fwd_vreg_vld, bus.ex4_fwd_vreg_vld,
                            bus.ex5_fwd_vreg_vld}), 64'h0);
        advance();
        idle(2);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 99) < 60, $urandom_range(0, 9) != 0,
                  7'($urandom), 2'($urandom),
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 7,
                  rnd64(), rnd64(), rnd64());
            compare_now();
            advance();
        end

        // reset mid-flight
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 7'(k + 8), 2'(k + 1), 0, 0,
                  rnd64(), rnd64(), rnd64());
            compare_now();
            advance();
        end
        drive(1, 1, 7'h0B, 2'b10, 0, 0, rnd64(), rnd64(), rnd64());
        rst_b = 1'b0;
        #1;
        chk_all_zero("midrst");
        q.delete();
        compare_now();
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        idle(1);

        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 99) < 60, $urandom_range(0, 9) != 0,
                  7'($urandom), 2'($urandom),
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 7,
                  rnd64(), rnd64(), rnd64());
            compare_now();
            advance();
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ct_vfpu_fwd_vreg_gen.md
Name: ct_vfpu_fwd_vreg_gen

Overview:
- Producer side of the vector-register forward bus for one VFPU pipe (pipe6 or pipe7); one instance per pipe.
- Tracks each issued instruction's destination vreg from ex1 through ex5.
- Per-instruction result latency is 3, 4 or 5 cycles.
- Drives the ex3/ex4/ex5 forward tags, valids and data consumed by the IDU RF-stage forward mux, including the ex5 writeback data.

Parameters:
- VREG_W, 7, physical vreg tag width.
- DATA_W, 64, forwarded data width.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst_b  in  1  asynchronous active-low reset.
- ex1_inst_vld  in  1  instruction valid in ex1.
- ex1_dst_vld  in  1  instruction writes a vreg.
- ex1_dst_vreg  in  VREG_W  destination physical vreg.
- ex1_lat  in  2  result stage: 2'b01=ex3, 2'b10=ex4, 2'b11=ex5; 2'b00 = no forward.
- pipe_stall  in  1  hold all stages.
- rtu_yy_xx_flush  in  1  kill speculative stages.
- ex3_result  in  DATA_W  datapath result, meaningful in ex3 for lat=ex3.
- ex4_result  in  DATA_W  datapath result, meaningful in ex4 for lat=ex4.
- ex5_result  in  DATA_W  datapath result, meaningful in ex5 for lat=ex5.
- ex3_fwd_vreg  out  VREG_W  ex3 tag.
- ex3_fwd_vreg_vld  out  1  ex3 forward valid.
- ex3_fwd_vreg_data  out  DATA_W  ex3 forward data.
- ex4_fwd_vreg  out  VREG_W  ex4 tag.
- ex4_fwd_vreg_vld  out  1  ex4 forward valid.
- ex4_fwd_vreg_data  out  DATA_W  ex4 forward data.
- ex5_fwd_vreg  out  VREG_W  ex5 tag.
- ex5_fwd_vreg_vld  out  1  ex5 forward valid.
- ex5_wb_vreg_data  out  DATA_W  ex5 writeback/forward data.

Behaviour:
- Clock and reset: single clock forever_cpuclk; reset cpurst_b is asynchronous, active-low.
- Reset: all stage valids, tags, latency fields and data registers = 0. All outputs = 0.
- Stage registers for ex2, ex3, ex4, ex5: vld, vreg, lat.
- ex2 load: ex2_vld <= ex1_inst_vld && ex1_dst_vld && (ex1_lat != 0).
- Advance: every cycle with pipe_stall=0, each stage loads the previous stage.
- pipe_stall=1: all stage registers and data registers hold. Outputs stay valid and stable while stalled.
- Flush: rtu_yy_xx_flush=1 clears ex2, ex3, ex4 valids next cycle, and the ex1 entry is not loaded.
  - ex5 is committed and is not killed.
  - Flush overrides stall.
  - An ex4 entry already valid moves into ex5 on a flush cycle only if pipe_stall=0; otherwise it is dropped.
- Data capture into ex4_data_q (on advance): ex3_result when ex3 lat=ex3.
- Data capture into ex5_data_q (on advance): ex4_fwd_vreg_data when ex4 lat<=ex4.
- Forward valids:
  - ex3_fwd_vreg_vld = ex3_vld && lat==ex3.
  - ex4_fwd_vreg_vld = ex4_vld && lat<=ex4.
  - ex5_fwd_vreg_vld = ex5_vld.
- Forward data:
  - ex3 data = ex3_result.
  - ex4 data = (lat==ex4) ? ex4_result : ex4_data_q.
  - ex5 data = (lat==ex5) ? ex5_result : ex5_data_q.
- Data gating: every *_data output is forced to 0 when its vld is 0, so the consumer mux never sees stale data.
- Tag outputs: each *_fwd_vreg = stage vreg register (held value, may be nonzero while vld=0).
- Latency: issue at ex1 cycle T gives ex3 at T+2, ex4 at T+3, ex5 at T+4, absent stalls.
- Tag uniqueness: at most one stage carries a given tag simultaneously, guaranteed by rename. No checking is done here.
- Reset mid-operation: asynchronous clear of everything; the first post-reset issue behaves normally.

Optional Feature:
- Macro: VFPU_FWD_EX3_EN.
- Defined: ex3 forwarding as above.
- Undefined:
  - ex3_fwd_vreg_vld and ex3_fwd_vreg_data tied 0.
  - lat=ex3 instructions first forward at ex4 with the captured ex3_result. This shortens the ex3 timing path.
  - ex3_fwd_vreg still drives the stage tag.

Test Plan:
- Issue vreg 7'h12, lat=ex3, result 64'hA5A5: ex3 vld=1, tag 12, data A5A5 at T+2; ex4 data A5A5 at T+3; ex5 wb data A5A5 at T+4; then all vld=0.
- Issue lat=ex5 vreg 7'h3F: ex3_vld=0 and ex4_vld=0; ex5_vld=1 at T+4 with data = ex5_result (drive 64'h1234).
- Back-to-back issues: vreg 1 lat=ex4, vreg 2 lat=ex3, vreg 3 lat=ex5:
  - Each stage's tag and vld correct every cycle.
  - Data never crosses between entries.
- pipe_stall for 3 cycles with lat=ex3 entry in ex4: ex4 vld/tag/data held constant; advances to ex5 on release.
- Flush with entries in ex2..ex5:
  - Next cycle ex3/ex4 vld=0.
  - Former ex4 entry appears in ex5 with vld=1.
  - Former ex5 entry leaves.
  - Simultaneous ex1 issue dropped.
- Assert cpurst_b low mid-flight: all outputs 0 immediately. Build without VFPU_FWD_EX3_EN: lat=ex3 entry shows ex3 vld=0, ex4 vld=1 with ex3-captured data.
